// File: rtl/nios_mul_sequencer.sv
// rtl/nios_mul_sequencer.sv - sequencer building a 32x32 unsigned multiply from an external 16x16 partial-product cell
//
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   req_valid/req_ready             request handshake; ready only while idle
//   req_src1, req_src2, req_op      operands A and B; op 0 = low word, op 1 = high word
//   resp_valid/resp_ready           response handshake
//   resp_result                     product word, stable while resp_valid is high
//   E_src1, E_src2, M_en            operands and register enable driven to the cell
//   M_mul_cell_p1/p2/p3             cell products lo1*lo2, lo1*hi2, hi1*lo2, valid one cycle after M_en
module nios_mul_sequencer #(
    parameter bit ENABLE_MULH = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic        req_op,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic [31:0] E_src1,
    output logic [31:0] E_src2,
    output logic        M_en,
    input  logic [31:0] M_mul_cell_p1,
    input  logic [31:0] M_mul_cell_p2,
    input  logic [31:0] M_mul_cell_p3
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE1 = 3'd1,
        CAP1   = 3'd2,
        ISSUE2 = 3'd3,
        CAP2   = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Only the upper halves of A and B are needed after the first cell pass.
    logic [15:0] a_hi;
    logic [15:0] b_hi;
    logic        op_q;
    logic [17:0] hp_q;

    logic [32:0] s_sum;
    logic [32:0] lo_sum;
    logic [17:0] hp_nxt;

    // Combine the first-pass partial products: the two cross terms are summed,
    // their low half is folded into the low word, and everything above bit 31
    // (cross-term high half plus the low-word carry) is kept for the high word.
    always_comb begin
        s_sum  = {1'b0, M_mul_cell_p2} + {1'b0, M_mul_cell_p3};
        lo_sum = {1'b0, M_mul_cell_p1} + {1'b0, s_sum[15:0], 16'h0000};
        hp_nxt = {1'b0, s_sum[32:16]} + {17'h0, lo_sum[32]};
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        M_en       = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = ISSUE1;
                end
            end
            ISSUE1: begin
                M_en      = 1'b1;
                state_nxt = CAP1;
            end
            CAP1: begin
                state_nxt = op_q ? ISSUE2 : RESP;
            end
            ISSUE2: begin
                M_en      = 1'b1;
                state_nxt = CAP2;
            end
            CAP2: begin
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                // Return to IDLE rather than accepting directly, so a new
                // request is never taken in the handshake cycle.
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            resp_result <= 32'h0;
            E_src1      <= 32'h0;
            E_src2      <= 32'h0;
            a_hi        <= 16'h0;
            b_hi        <= 16'h0;
            op_q        <= 1'b0;
            hp_q        <= 18'h0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_hi   <= req_src1[31:16];
                        b_hi   <= req_src2[31:16];
                        op_q   <= req_op & ENABLE_MULH;
                        // Cell operands are loaded on entry so they are
                        // already presented during ISSUE1.
                        E_src1 <= req_src1;
                        E_src2 <= req_src2;
                    end
                end
                CAP1: begin
                    hp_q <= hp_nxt;
                    if (op_q) begin
                        // Second pass reuses the cell's lo*lo product for hi1*hi2.
                        E_src1 <= {16'h0, a_hi};
                        E_src2 <= {16'h0, b_hi};
                    end else begin
                        resp_result <= lo_sum[31:0];
                    end
                end
                CAP2: begin
                    resp_result <= M_mul_cell_p1 + {14'h0, hp_q};
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/nios_mul_sequencer.md
NIOS_MUL_SEQUENCER -- requirements
Module: nios_mul_sequencer

Interface
REQ-001 Parameter ENABLE_MULH, default 1: when 1, op=1 returns the high word of the unsigned 64-bit product; when 0, op=1 is treated as op=0.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  request offered.
REQ-005 req_ready  out  1  sequencer can accept; high only in IDLE.
REQ-006 req_src1  in  32  unsigned multiplicand A.
REQ-007 req_src2  in  32  unsigned multiplier B.
REQ-008 req_op  in  1  0 = low 32 bits of A*B; 1 = high 32 bits of A*B.
REQ-009 resp_valid  out  1  result available.
REQ-010 resp_ready  in  1  consumer accepts result.
REQ-011 resp_result  out  32  product word.
REQ-012 E_src1  out  32  operand 1 to the 16x16 partial-product cell.
REQ-013 E_src2  out  32  operand 2 to the cell.
REQ-014 M_en  out  1  cell register enable.
REQ-015 M_mul_cell_p1/p2/p3  in  32 each  cell products: lo1*lo2, lo1*hi2, hi1*lo2; valid one cycle after the edge at which M_en=1.

Function
REQ-016 States SHALL be IDLE, ISSUE1, CAP1, ISSUE2, CAP2, RESP.
REQ-017 IDLE: req_ready=1; on req_valid, latch A, B and op (op forced to 0 if ENABLE_MULH=0); next state ISSUE1.
REQ-018 ISSUE1: E_src1=A, E_src2=B, M_en=1; next state CAP1.
REQ-019 CAP1: M_en=0; compute s=p2+p3 (33 bits) and {c,lo}=p1+(s[15:0]<<16) (33 bits); register lo and hp=(s>>16)+c (18 bits).
REQ-020 CAP1 transition: op=0 goes to RESP with resp_result=lo; op=1 goes to ISSUE2.
REQ-021 ISSUE2: E_src1={16'h0,A[31:16]}, E_src2={16'h0,B[31:16]}, M_en=1; next state CAP2.
REQ-022 CAP2: resp_result = p1 + hp, mod 2^32, where p1 = hi1*hi2; next state RESP.
REQ-023 RESP: resp_valid=1 and resp_result held stable until resp_valid&&resp_ready; then go to IDLE.
REQ-024 Latency from the accept edge to resp_valid high: 3 cycles for op=0 and 5 cycles for op=1.
REQ-025 Outside ISSUE1/ISSUE2, M_en=0 and E_src1/E_src2 hold their last values.
REQ-026 req_valid outside IDLE SHALL be ignored; no queuing.
REQ-027 No new request is accepted in the cycle of the response handshake; the earliest next accept is the following cycle.
REQ-028 Arithmetic is unsigned; no overflow flags are produced.

Reset
REQ-029 reset=1 at any edge, including mid-operation, forces:
- state IDLE;
- resp_valid=0, resp_result=0;
- M_en=0, E_src1=0, E_src2=0.
REQ-030 An in-flight operation aborted by reset SHALL produce no response.
REQ-031 req_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-032 Basic product: A=0x0001_0003, B=0x0002_0005.
- op=0 -> resp_result=0x000B_000F after 3 cycles.
- op=1 -> resp_result=0x0000_0002 after 5 cycles.
REQ-033 Carry propagation: A=B=0xFFFF_FFFF.
- op=0 -> 0x0000_0001.
- op=1 -> 0xFFFF_FFFE.
REQ-034 Backpressure: hold resp_ready=0 for 4 cycles in RESP -> resp_valid=1 and resp_result stable throughout, req_ready=0; response completes on the first cycle resp_ready=1.
REQ-035 Reset during ISSUE2 -> no resp_valid pulse, req_ready=1 the next cycle, outputs zero; a subsequent request completes correctly.
REQ-036 Busy and back-to-back behaviour:
- req_valid held high with changing operands while busy -> only the first request is serviced.
- Back-to-back requests are accepted one cycle after each response handshake.
REQ-037 ENABLE_MULH=0, op=1, A=B=0xFFFF_FFFF -> resp_result=0x0000_0001 after 3 cycles; M_en pulses exactly once.
